serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow flip-flop.
- Companion to the combinational full-adder datapath: it performs the inverse operation for area-constrained paths where latency is acceptable.
- Uses a valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- bout  output  1  final borrow; 1 iff a < b unsigned
- ovf  output  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow and counter cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and not presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a into sa and b into sb, borrow<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0; in_valid and a/b are ignored.
  - Each edge computes:
    - d = sa[0]^sb[0]^borrow
    - borrow <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow)
  - Shift sa and sb right by 1; shift d into the MSB of the result register (shift right).
  - cnt <= cnt+1. On the edge where cnt==WIDTH-1, go to DONE.
  - cnt width is clog2(WIDTH+1).
- DONE:
  - out_valid=1.
  - diff, bout and ovf hold stable and registered until handshake.
  - On an edge with out_ready=1: go to IDLE with out_valid=0. diff/bout retain their last value; no clear is required.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Throughput is at most one operation per WIDTH+2 cycles with out_ready held high.
- No combinational paths from inputs to outputs; all outputs are registered or decoded from state.
- Result arithmetic:
  - diff equals (a - b) mod 2^WIDTH.
  - bout equals the borrow after bit WIDTH-1.
  - Outputs of a DONE result are for the operands latched at acceptance, regardless of later a/b changes.
- Boundary cases:
  - WIDTH=1: a single RUN cycle.
  - a==b: diff=0, bout=0.
  - a=0, b=max: diff=1, bout=1.
  - out_ready held high on entry to DONE: out_valid is high for exactly one cycle.
  - out_ready held low: DONE persists indefinitely.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Port ovf exists.
  - In the final RUN cycle, capture ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the sa/sb MSB bits present in that cycle.
  - ovf is valid with out_valid and cleared by reset.
- When undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, out_ready=1 -> out_valid rises 8 edges after accept; diff=8'h37, bout=0, in_ready low for the whole operation.
- a=8'h10, b=8'h20 -> diff=8'hF0, bout=1. Then a=8'h00, b=8'hFF -> diff=8'h01, bout=1. Then a=b=8'hFF -> diff=8'h00, bout=0.
- Backpressure and busy input:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and bout stable.
  - Pulse in_valid with a=8'hAA during RUN -> ignored; the result still matches the first operands.
- Reset mid-RUN: assert rst at RUN cycle 3 -> next cycle in_ready=1, out_valid=0, diff=0. A following op 8'h05-8'h03 gives 8'h02.
- SERIAL_SUB_OVF_EN:
  - 8'h80-8'h01 -> diff=8'h7F, ovf=1, bout=0.
  - 8'h7F-8'hFF -> diff=8'h80, ovf=1, bout=1.
  - 8'h05-8'h03 -> ovf=0.
- WIDTH=1 instance: a=0, b=1 -> diff=1, bout=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor bit per clock.
// Optional signed-overflow output enabled with `define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q;
    logic [WIDTH-1:0] sa_d, sb_d, res_d;
    logic             borrow_q, borrow_d;
    logic             bout_q;
    logic             d_bit;
    logic             last;
    logic [CW-1:0]    cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    always_comb begin
        d_bit    = sa_q[0] ^ sb_q[0] ^ borrow_q;
        borrow_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        // result fills from the top so bit 0 lands at LSB after WIDTH shifts
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = d_bit;
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sa_q     <= sa_d;
                    sb_q     <= sb_d;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        bout_q  <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
                        // operand MSBs sit in bit 0 on the final cycle
                        ovf_q   <= (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ d_bit);
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, bout;
    logic [7:0] diff;
    logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, bout1;
    logic [0:0] diff1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf1;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; hold>0 keeps out_ready low for that many DONE cycles,
    // poke drives a bogus operand mid-RUN that must be ignored.
    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int hold, input bit poke);
        a = av; b = bv; in_valid = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'(0));
            if (i == 2 && poke) begin
                a = 8'hAA; b = 8'h00; in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            if (i == 7) chk({tag, ".out_valid_early"}, 64'(out_valid), 64'(0));
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".diff"}, 64'(diff), 64'(ed));
        chk({tag, ".bout"}, 64'(bout), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo) begin end
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_diff"}, 64'(diff), 64'(ed));
            chk({tag, ".hold_bout"}, 64'(bout), 64'(eb));
        end
        out_ready = 1'b1;
        step();
        chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'(0));
        chk({tag, ".in_ready_back"}, 64'(in_ready), 64'(1));
        chk({tag, ".diff_retained"}, 64'(diff), 64'(ed));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.diff", 64'(diff), 64'(0));
        chk("rst.bout", 64'(bout), 64'(0));
        chk("rst.w1_in_ready", 64'(in_ready1), 64'(1));
`ifdef SERIAL_SUB_OVF_EN
        chk("rst.ovf", 64'(ovf), 64'(0));
`endif

        do_op("5A-23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 1'b0);
        do_op("10-20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 1'b0);
        do_op("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 1'b0);
        do_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        do_op("3C-1C_bp", 8'h3C, 8'h1C, 8'h20, 1'b0, 1'b0, 5, 1'b1);

        // abort an operation in RUN cycle 3
        a = 8'h77; b = 8'h11; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.in_ready", 64'(in_ready), 64'(1));
        chk("abort.out_valid", 64'(out_valid), 64'(0));
        chk("abort.diff", 64'(diff), 64'(0));
        do_op("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        do_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
        do_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 1'b0);

        // WIDTH=1: 0 - 1
        a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("w1.in_ready_busy", 64'(in_ready1), 64'(0));
        chk("w1.out_valid_early", 64'(out_valid1), 64'(0));
        step();
        chk("w1.out_valid", 64'(out_valid1), 64'(1));
        chk("w1.diff", 64'(diff1), 64'(1));
        chk("w1.bout", 64'(bout1), 64'(1));
`ifdef SERIAL_SUB_OVF_EN
        chk("w1.ovf", 64'(ovf1), 64'(1));
`endif
        step();
        chk("w1.out_valid_drop", 64'(out_valid1), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
